// File: rtl/interrupt_controller.sv
// interrupt_controller: Game Boy Color interrupt controller.
// Holds IF (0xFF0F) and IE (0xFFFF). Owns IME, including the one-instruction EI delay.
// Presents a prioritised request to the CPU control unit.
// Runs the IDLE -> DISPATCH -> VECTOR handshake that delivers the vector and clears
// the serviced IF bit.
// Optional feature macro: INTC_DISPATCH_CANCEL_EN.
//   Defined: the winner is chosen at int_sel_i, and an emptied pending set yields
//            vector 16'h0000.
//   Default: the winner and vector are latched at int_ack_i.

module interrupt_controller #(
    parameter logic [15:0] IF_ADDR = 16'hFF0F,
    parameter logic [15:0] IE_ADDR = 16'hFFFF,
    parameter int          NUM_IRQ = 5
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_IRQ-1:0] irq_i,
    input  logic [15:0]        addr_i,
    input  logic [7:0]         wdata_i,
    input  logic               wr_i,
    output logic [7:0]         rdata_o,
    output logic               rhit_o,
    input  logic               instr_done_i,
    input  logic               ime_set_i,
    input  logic               ime_set_now_i,
    input  logic               ime_clr_i,
    output logic               int_pending_o,
    output logic               int_req_o,
    input  logic               int_ack_i,
    input  logic               int_sel_i,
    output logic [15:0]        int_vector_o,
    output logic               int_vector_valid_o,
    output logic               ime_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DISPATCH,
        S_VECTOR
    } state_e;

    localparam logic [15:0] VEC_BASE = 16'h0040;

    state_e             state_q, state_d;
    logic [NUM_IRQ-1:0] if_q, if_d;
    logic [7:0]         ie_q, ie_d;
    logic               ime_q, ime_d;
    logic               ei_pend_q, ei_pend_d;
    logic [15:0]        vec_q, vec_d;
`ifdef INTC_DISPATCH_CANCEL_EN
`else
    logic [2:0]         idx_q, idx_d;
`endif

    logic [NUM_IRQ-1:0] pend_vec;
    logic [NUM_IRQ-1:0] clr_mask;
    logic               win_valid;
    logic [2:0]         win_idx;
    logic [15:0]        win_vec;
    logic               wr_if, wr_ie;
    logic               ack_take, sel_take;

    assign wr_if    = wr_i && (addr_i == IF_ADDR);
    assign wr_ie    = wr_i && (addr_i == IE_ADDR);
    assign pend_vec = ie_q[NUM_IRQ-1:0] & if_q;
    assign ack_take = int_ack_i && int_req_o;
    assign sel_take = int_sel_i && (state_q == S_DISPATCH);
    assign win_vec  = VEC_BASE + {10'd0, win_idx, 3'd0};

    // Lowest-numbered pending source wins; scanning downward lets the lowest index
    // overwrite any higher one.
    // NOTE: every signal written in a combinational block gets a default first,
    // otherwise an unassigned path infers a latch.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = 3'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (pend_vec[i]) begin
                win_valid = 1'b1;
                win_idx   = 3'(i);
            end
        end
    end

    // Bus read mux: IF reads back with its unused upper bits set.
    always_comb begin
        rhit_o  = (addr_i == IF_ADDR) || (addr_i == IE_ADDR);
        rdata_o = 8'h00;
        if (addr_i == IF_ADDR) begin
            rdata_o = {3'b111, if_q};
        end else if (addr_i == IE_ADDR) begin
            rdata_o = ie_q;
        end
    end

    // Next values for IF, IE, IME, the EI delay flag and the dispatch vector.
    always_comb begin
        ie_d      = wr_ie ? wdata_i : ie_q;
        ime_d     = ime_q;
        ei_pend_d = ei_pend_q;
        vec_d     = vec_q;
        clr_mask  = '0;
`ifdef INTC_DISPATCH_CANCEL_EN
        if (sel_take) begin
            if (win_valid) begin
                vec_d             = win_vec;
                clr_mask[win_idx] = 1'b1;
            end else begin
                vec_d = 16'h0000;
            end
        end
`else
        idx_d = idx_q;
        if (ack_take) begin
            idx_d = win_idx;
            vec_d = win_vec;
        end
        if (sel_take) begin
            clr_mask[idx_q] = 1'b1;
        end
`endif
        // A request pulse in the same cycle always wins over a write or a clear.
        if_d = ((wr_if ? wdata_i[NUM_IRQ-1:0] : if_q) & ~clr_mask) | irq_i;

        if (ime_clr_i || ack_take) begin
            ime_d     = 1'b0;
            ei_pend_d = 1'b0;
        end else begin
            if (ime_set_now_i) begin
                ime_d = 1'b1;
            end
            // Only an EI from an earlier cycle is promoted at this boundary.
            if (instr_done_i && ei_pend_q) begin
                ime_d     = 1'b1;
                ei_pend_d = 1'b0;
            end
            if (ime_set_i) begin
                ei_pend_d = 1'b1;
            end
        end
    end

    // Datapath registers.
    // NOTE: sequential state uses non-blocking assignments, so every flop samples
    // the pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            if_q      <= '0;
            ie_q      <= 8'h00;
            ime_q     <= 1'b0;
            ei_pend_q <= 1'b0;
            vec_q     <= 16'h0000;
        end else begin
            if_q      <= if_d;
            ie_q      <= ie_d;
            ime_q     <= ime_d;
            ei_pend_q <= ei_pend_d;
            vec_q     <= vec_d;
        end
    end

`ifdef INTC_DISPATCH_CANCEL_EN
`else
    // Index of the source accepted at int_ack_i, cleared later at int_sel_i.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            idx_q <= 3'd0;
        end else begin
            idx_q <= idx_d;
        end
    end
`endif

    // Dispatch FSM state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Dispatch FSM next state: VECTOR lasts exactly one cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:     if (ack_take) state_d = S_DISPATCH;
            S_DISPATCH: if (int_sel_i) state_d = S_VECTOR;
            S_VECTOR:   state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // Dispatch FSM outputs and status.
    always_comb begin
        int_pending_o      = |pend_vec;
        int_req_o          = ime_q && (|pend_vec) && (state_q == S_IDLE);
        int_vector_valid_o = (state_q == S_VECTOR);
        int_vector_o       = vec_q;
        ime_o              = ime_q;
    end

endmodule

// File: tb/tb_interrupt_controller.sv
// Testbench for interrupt_controller: directed scenarios plus randomized traffic
// compared against a behavioural model of IF/IE/IME and the dispatch handshake.

module tb_interrupt_controller;

    localparam logic [15:0] IF_A = 16'hFF0F;
    localparam logic [15:0] IE_A = 16'hFFFF;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic [4:0]  irq_i = '0;
    logic [15:0] addr_i = '0;
    logic [7:0]  wdata_i = '0;
    logic        wr_i = 1'b0;
    logic [7:0]  rdata_o;
    logic        rhit_o;
    logic        instr_done_i = 1'b0;
    logic        ime_set_i = 1'b0;
    logic        ime_set_now_i = 1'b0;
    logic        ime_clr_i = 1'b0;
    logic        int_pending_o;
    logic        int_req_o;
    logic        int_ack_i = 1'b0;
    logic        int_sel_i = 1'b0;
    logic [15:0] int_vector_o;
    logic        int_vector_valid_o;
    logic        ime_o;

    int errors = 0;
    int checks = 0;

    interrupt_controller dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .irq_i              (irq_i),
        .addr_i             (addr_i),
        .wdata_i            (wdata_i),
        .wr_i               (wr_i),
        .rdata_o            (rdata_o),
        .rhit_o             (rhit_o),
        .instr_done_i       (instr_done_i),
        .ime_set_i          (ime_set_i),
        .ime_set_now_i      (ime_set_now_i),
        .ime_clr_i          (ime_clr_i),
        .int_pending_o      (int_pending_o),
        .int_req_o          (int_req_o),
        .int_ack_i          (int_ack_i),
        .int_sel_i          (int_sel_i),
        .int_vector_o       (int_vector_o),
        .int_vector_valid_o (int_vector_valid_o),
        .ime_o              (ime_o)
    );

    always #5 clk_i = ~clk_i;

    // Behavioural model state: phase 0 idle, 1 dispatching, 2 vector delivered.
    logic [4:0]  m_if;
    logic [7:0]  m_ie;
    bit          m_ime;
    bit          m_ei;
    int          m_phase;
    int          m_idx;
    logic [15:0] m_vec;

    function automatic int lowest_set(input logic [4:0] v);
        for (int i = 0; i < 5; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_if = '0; m_ie = '0; m_ime = 0; m_ei = 0;
        m_phase = 0; m_idx = 0; m_vec = '0;
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        logic [4:0] pend;
        logic [4:0] nif;
        logic [4:0] clr;
        int low;
        bit req, ack, sel;
        pend = m_ie[4:0] & m_if;
        low  = lowest_set(pend);
        req  = m_ime && (pend != 0) && (m_phase == 0);
        ack  = int_ack_i && req;
        sel  = int_sel_i && (m_phase == 1);
        nif  = (wr_i && addr_i == IF_A) ? wdata_i[4:0] : m_if;
        clr  = '0;
`ifdef INTC_DISPATCH_CANCEL_EN
        if (sel) begin
            if (low >= 0) begin
                clr[low] = 1'b1;
                m_vec = 16'(64 + 8 * low);
            end else begin
                m_vec = 16'h0000;
            end
        end
`else
        if (ack) begin
            m_idx = low;
            m_vec = 16'(64 + 8 * low);
        end
        if (sel) clr[m_idx] = 1'b1;
`endif
        m_if = (nif & ~clr) | irq_i;
        if (wr_i && addr_i == IE_A) m_ie = wdata_i;
        if (ime_clr_i || ack) begin
            m_ime = 0; m_ei = 0;
        end else begin
            if (ime_set_now_i) m_ime = 1;
            if (instr_done_i && m_ei) begin m_ime = 1; m_ei = 0; end
            if (ime_set_i) m_ei = 1;
        end
        if (m_phase == 0 && ack) m_phase = 1;
        else if (m_phase == 1 && sel) m_phase = 2;
        else if (m_phase == 2) m_phase = 0;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk_i);
        #1;
        irq_i = '0; wr_i = 0; instr_done_i = 0; ime_set_i = 0;
        ime_set_now_i = 0; ime_clr_i = 0; int_ack_i = 0; int_sel_i = 0;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        model_reset();
        #3;
        rst_i = 1'b0;
        #1;
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        addr_i = a; wdata_i = d; wr_i = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        addr_i = 16'h1234; #1;
        checks++; if (rdata_o !== 8'h00 || rhit_o !== 1'b0) begin errors++; $display("FAIL reset_rdata got %h/%b exp 00/0", rdata_o, rhit_o); end
        checks++; if ({int_pending_o, int_req_o, int_vector_valid_o, ime_o} !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b exp 0000", {int_pending_o, int_req_o, int_vector_valid_o, ime_o}); end
        checks++; if (int_vector_o !== 16'h0000) begin errors++; $display("FAIL reset_vector got %h exp 0000", int_vector_o); end
        addr_i = IF_A; #1;
        checks++; if (rdata_o !== 8'hE0 || rhit_o !== 1'b1) begin errors++; $display("FAIL reset_if got %h/%b exp e0/1", rdata_o, rhit_o); end
        addr_i = IE_A; #1;
        checks++; if (rdata_o !== 8'h00 || rhit_o !== 1'b1) begin errors++; $display("FAIL reset_ie got %h/%b exp 00/1", rdata_o, rhit_o); end
    endtask

    task automatic test_reset_mid_dispatch();
        do_reset();
        bus_write(IE_A, 8'h1F);
        ime_set_now_i = 1; tick();
        irq_i = 5'b00100; tick();
        checks++; if (int_req_o !== 1'b1) begin errors++; $display("FAIL rmd_req got %b exp 1", int_req_o); end
        int_ack_i = 1; tick();
        checks++; if (ime_o !== 1'b0 || int_req_o !== 1'b0) begin errors++; $display("FAIL rmd_dispatch got ime=%b req=%b exp 0 0", ime_o, int_req_o); end
        do_reset();
        addr_i = IF_A; #1;
        checks++; if (rdata_o !== 8'hE0) begin errors++; $display("FAIL rmd_if got %h exp e0", rdata_o); end
        addr_i = IE_A; #1;
        checks++; if (rdata_o !== 8'h00) begin errors++; $display("FAIL rmd_ie got %h exp 00", rdata_o); end
        checks++; if (ime_o !== 1'b0) begin errors++; $display("FAIL rmd_ime got %b exp 0", ime_o); end
        int_sel_i = 1; tick();
        for (int k = 0; k < 3; k++) begin
            checks++; if (int_vector_valid_o !== 1'b0) begin errors++; $display("FAIL rmd_valid cycle %0d got %b exp 0", k, int_vector_valid_o); end
            tick();
        end
    endtask

    task automatic test_priority();
        do_reset();
        bus_write(IE_A, 8'h1F);
        ime_set_now_i = 1; tick();
        irq_i = 5'b10110; tick();
        checks++; if (int_req_o !== 1'b1) begin errors++; $display("FAIL prio_req got %b exp 1", int_req_o); end
        int_ack_i = 1; tick();
        checks++; if (ime_o !== 1'b0) begin errors++; $display("FAIL prio_ime got %b exp 0", ime_o); end
        int_sel_i = 1; tick();
        checks++; if (int_vector_valid_o !== 1'b1 || int_vector_o !== 16'h0048) begin errors++; $display("FAIL prio_vector got %b/%h exp 1/0048", int_vector_valid_o, int_vector_o); end
        tick();
        checks++; if (int_vector_valid_o !== 1'b0 || int_vector_o !== 16'h0048) begin errors++; $display("FAIL prio_hold got %b/%h exp 0/0048", int_vector_valid_o, int_vector_o); end
        addr_i = IF_A; #1;
        checks++; if (rdata_o !== 8'hF4) begin errors++; $display("FAIL prio_if got %h exp f4", rdata_o); end
    endtask

    task automatic test_ei_delay();
        do_reset();
        ime_set_i = 1; instr_done_i = 1; tick();
        for (int k = 1; k <= 3; k++) begin
            checks++; if (ime_o !== 1'b0) begin errors++; $display("FAIL ei_delay t+%0d got %b exp 0", k, ime_o); end
            if (k == 3) instr_done_i = 1;
            tick();
        end
        checks++; if (ime_o !== 1'b1) begin errors++; $display("FAIL ei_delay t+4 got %b exp 1", ime_o); end
        ime_clr_i = 1; tick();
        ime_set_i = 1; tick();
        ime_clr_i = 1; tick();
        instr_done_i = 1; tick();
        checks++; if (ime_o !== 1'b0) begin errors++; $display("FAIL ei_then_di got %b exp 0", ime_o); end
        ime_set_i = 1; tick();
        ime_set_i = 1; tick();
        instr_done_i = 1; tick();
        checks++; if (ime_o !== 1'b1) begin errors++; $display("FAIL ei_repeat got %b exp 1", ime_o); end
        ime_clr_i = 1; ime_set_now_i = 1; tick();
        checks++; if (ime_o !== 1'b0) begin errors++; $display("FAIL di_beats_reti got %b exp 0", ime_o); end
    endtask

    task automatic test_simultaneous_write();
        do_reset();
        addr_i = IF_A; wdata_i = 8'h01; wr_i = 1; irq_i = 5'b00100; tick();
        #1;
        checks++; if (rdata_o !== 8'hE5) begin errors++; $display("FAIL wr_pulse_if got %h exp e5", rdata_o); end
    endtask

    task automatic test_cancel();
        logic [15:0] exp_vec;
        logic [7:0]  exp_if;
`ifdef INTC_DISPATCH_CANCEL_EN
        exp_vec = 16'h0000; exp_if = 8'hE1;
`else
        exp_vec = 16'h0040; exp_if = 8'hE0;
`endif
        do_reset();
        bus_write(IF_A, 8'h01);
        bus_write(IE_A, 8'h01);
        ime_set_now_i = 1; tick();
        int_ack_i = 1; tick();
        bus_write(IE_A, 8'h00);
        int_sel_i = 1; tick();
        checks++; if (int_vector_valid_o !== 1'b1 || int_vector_o !== exp_vec) begin errors++; $display("FAIL cancel_vector got %b/%h exp 1/%h", int_vector_valid_o, int_vector_o, exp_vec); end
        tick();
        addr_i = IF_A; #1;
        checks++; if (rdata_o !== exp_if) begin errors++; $display("FAIL cancel_if got %h exp %h", rdata_o, exp_if); end
    endtask

    task automatic test_halt_wake();
        do_reset();
        bus_write(IE_A, 8'h04);
        checks++; if (int_pending_o !== 1'b0) begin errors++; $display("FAIL halt_idle got %b exp 0", int_pending_o); end
        irq_i = 5'b00100; tick();
        checks++; if (int_pending_o !== 1'b1 || int_req_o !== 1'b0) begin errors++; $display("FAIL halt_wake got pend=%b req=%b exp 1 0", int_pending_o, int_req_o); end
    endtask

    task automatic test_random();
        logic [7:0] exp_rd;
        bit exp_pend, exp_req;
        for (int n = 0; n < 3000; n++) begin
            irq_i = ($urandom_range(0, 5) == 0) ? 5'($urandom) : 5'd0;
            case ($urandom_range(0, 3))
                0:       addr_i = IF_A;
                1:       addr_i = IE_A;
                default: addr_i = 16'($urandom);
            endcase
            wr_i          = ($urandom_range(0, 5) == 0);
            wdata_i       = 8'($urandom);
            ime_clr_i     = ($urandom_range(0, 19) == 0);
            ime_set_i     = ($urandom_range(0, 7) == 0);
            ime_set_now_i = ($urandom_range(0, 7) == 0);
            instr_done_i  = ($urandom_range(0, 2) == 0);
            int_ack_i     = ($urandom_range(0, 2) == 0);
            int_sel_i     = ($urandom_range(0, 2) == 0);
            #1;
            exp_pend = |(m_ie[4:0] & m_if);
            exp_req  = m_ime && exp_pend && (m_phase == 0);
            exp_rd   = (addr_i == IF_A) ? {3'b111, m_if} : (addr_i == IE_A) ? m_ie : 8'h00;
            checks++; if (ime_o !== m_ime) begin errors++; $display("FAIL rnd_ime cyc %0d got %b exp %b", n, ime_o, m_ime); end
            checks++; if (int_pending_o !== exp_pend) begin errors++; $display("FAIL rnd_pending cyc %0d got %b exp %b", n, int_pending_o, exp_pend); end
            checks++; if (int_req_o !== exp_req) begin errors++; $display("FAIL rnd_req cyc %0d got %b exp %b", n, int_req_o, exp_req); end
            checks++; if (int_vector_valid_o !== (m_phase == 2)) begin errors++; $display("FAIL rnd_valid cyc %0d got %b exp %b", n, int_vector_valid_o, m_phase == 2); end
            checks++; if (int_vector_o !== m_vec) begin errors++; $display("FAIL rnd_vector cyc %0d got %h exp %h", n, int_vector_o, m_vec); end
            checks++; if (rhit_o !== (addr_i == IF_A || addr_i == IE_A)) begin errors++; $display("FAIL rnd_rhit cyc %0d got %b", n, rhit_o); end
            checks++; if (rdata_o !== exp_rd) begin errors++; $display("FAIL rnd_rdata cyc %0d got %h exp %h", n, rdata_o, exp_rd); end
            tick();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired exp completion before 1ms");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        @(posedge clk_i);
        #1;
        test_reset();
        test_reset_mid_dispatch();
        test_priority();
        test_ei_delay();
        test_simultaneous_write();
        test_cancel();
        test_halt_wake();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
- Game Boy Color interrupt controller; sits directly upstream of the CPU control unit.
- Latches peripheral interrupt requests into IF (0xFF0F) and holds the IE mask (0xFFFF).
- Owns IME, including the one-instruction EI delay.
- Presents a prioritised request to the control unit and runs the dispatch handshake that selects the vector and clears the serviced IF bit.

Parameters:
- IF_ADDR, 16'hFF0F: IF register address.
- IE_ADDR, 16'hFFFF: IE register address.
- NUM_IRQ, 5: interrupt sources. Fixed at 5; other values unsupported.

Ports:
- clk_i  input  1  system clock
- rst_i  input  1  reset; asynchronous, active-high
- irq_i  input  5  single-cycle request pulses: [0] VBlank, [1] STAT, [2] Timer, [3] Serial, [4] Joypad
- addr_i  input  16  CPU bus address
- wdata_i  input  8  CPU bus write data
- wr_i  input  1  bus write strobe
- rdata_o  output  8  read data; combinational; valid when rhit_o=1
- rhit_o  output  1  addr_i matches IF_ADDR or IE_ADDR
- instr_done_i  input  1  pulse: an instruction boundary is reached
- ime_set_i  input  1  EI executed
- ime_set_now_i  input  1  RETI executed; immediate enable
- ime_clr_i  input  1  DI executed
- int_pending_o  output  1  |(IE[4:0] & IF); HALT wake; independent of IME
- int_req_o  output  1  IME & int_pending_o & state==IDLE
- int_ack_i  input  1  control unit begins dispatch
- int_sel_i  input  1  control unit reaches the vector-select point (after the PC high byte is pushed)
- int_vector_o  output  16  dispatch vector
- int_vector_valid_o  output  1  one-cycle pulse; vector valid
- ime_o  output  1  current IME

Behaviour:
- Reset (async, any state):
  - IF=5'h00, IE=8'h00, IME=0, ei_pend=0, state=IDLE.
  - All outputs 0; rdata_o=0.
- IF bits:
  - Each irq_i[n] pulse sets IF[n] on the next clk_i edge.
  - Bus write to IF_ADDR loads wdata_i[4:0].
  - If a write and a pulse hit the same cycle: IF <= wdata_i[4:0] | irq_i (hardware set wins).
- IE: bus write to IE_ADDR loads all 8 bits.
- Reads: IF reads {3'b111, IF}; IE reads the full 8 bits; rdata_o=0 when rhit_o=0.
- IME control:
  - ime_clr_i: IME<=0 and ei_pend<=0 next edge.
  - ime_set_now_i: IME<=1 next edge.
  - ime_set_i: ei_pend<=1. IME<=1 on the first instr_done_i strictly after the ime_set_i cycle; ei_pend then clears.
  - instr_done_i in the same cycle as ime_set_i does not promote.
- IME priorities when events coincide:
  - ime_clr_i beats ime_set_i, ime_set_now_i, a promoting instr_done_i, and int_ack_i.
  - EI followed by DI before the boundary leaves IME=0.
  - Repeated EI is idempotent.
- Priority: lowest set bit of IE[4:0] & IF wins. Vector = 16'h0040 + 8*index (0x40, 0x48, 0x50, 0x58, 0x60).
- FSM states: IDLE, DISPATCH, VECTOR.
- IDLE -> DISPATCH:
  - Taken on int_ack_i when int_req_o=1.
  - IME<=0 and ei_pend<=0 at that edge.
  - int_ack_i in any other condition is ignored.
- DISPATCH -> VECTOR on int_sel_i:
  - Latch the winning index from IE & IF at that edge; clear that IF bit.
  - If an irq_i pulse targets the same bit in that cycle, the bit stays set.
  - If no bit is pending, latch vector 16'h0000 and clear nothing (cancellation).
- VECTOR -> IDLE unconditionally after 1 cycle:
  - int_vector_valid_o=1 for exactly that cycle.
  - int_vector_o holds the latched value until the next dispatch.
- int_sel_i outside DISPATCH is ignored.
- Latency: vector valid 1 cycle after the int_sel_i edge.
- Bus writes to IE/IF during DISPATCH take effect normally and influence selection.

Optional Feature:
- Macro: INTC_DISPATCH_CANCEL_EN.
- Defined: vector is selected at int_sel_i as above; a pending set emptied by an IE/IF write during DISPATCH yields 16'h0000.
- Undefined:
  - Index and vector are latched at int_ack_i.
  - int_sel_i only clears the latched IF bit and pulses valid.
  - No 0x0000 cancellation; later IE/IF writes do not change the vector.

Test Plan:
- Reset mid-dispatch:
  - Stimulus: IE=0x1F, IME=1, irq_i=5'b00100, ack, assert rst_i before sel.
  - Required: state IDLE; IF reads 0xE0; IE 0x00; ime_o=0; valid never pulses.
- Priority:
  - Stimulus: IE=0x1F, irq_i=5'b10110 together, IME=1; ack then sel.
  - Required: int_vector_o=0x0048; IF reads 0xF4; ime_o=0.
- EI delay:
  - Stimulus: ime_set_i at cycle t; instr_done_i at t and t+3.
  - Required: ime_o=0 through t+3; ime_o=1 from t+4. EI then DI before t+3 leaves ime_o=0.
- Simultaneous write/pulse:
  - Stimulus: write IF=0x01 while irq_i=5'b00100.
  - Required: IF reads 0xE5.
- Cancellation (macro defined):
  - Stimulus: IF=0x01, IE=0x01, IME=1, ack; write IE=0x00 before sel.
  - Required: vector 0x0000; IF stays 0x01.
  - Same sequence with the macro undefined: vector 0x0040; IF reads 0xE0.
- HALT wake:
  - Stimulus: IME=0, IE=0x04, irq_i[2] pulse.
  - Required: int_pending_o=1 next cycle; int_req_o=0.
